// File: rtl/usb_cmd_pkg.sv
// usb_cmd_pkg: shared constants, state encoding and helpers for the USB command initiator
package usb_cmd_pkg;
  localparam logic [23:0] CMD_TRIGGER = "CMD";
  localparam logic [23:0] RSP_COMPLETE = "CMP";
  localparam logic [7:0] CMD_ID_I = "I";
  localparam logic [7:0] CMD_ID_W = "W";
  localparam logic [7:0] CMD_ID_D = "D";
  localparam logic [7:0] CMD_ID_Q = "Q";
  localparam logic [3:0] PARAM_LEN_W = 4'd8;
  localparam logic [3:0] PARAM_LEN_D = 4'd4;
  typedef enum logic [2:0] {IDLE, TRIGGER, PARAM, FETCH, DATA, RSP, DONE} state_t;
  function automatic logic known_cmd(input logic [7:0] c);
    return c == CMD_ID_I || c == CMD_ID_W || c == CMD_ID_D;
  endfunction
endpackage

// File: rtl/usb_cmd_initiator_if.sv
// usb_cmd_initiator_if: command, word-data and FSI byte-stream signals of the initiator
interface usb_cmd_initiator_if;
  logic i_start;
  logic [7:0] i_cmd;
  logic [3:0] i_bank;
  logic [23:0] i_address;
  logic [19:0] i_length;
  logic o_busy;
  logic o_done;
  logic o_error;
  logic [31:0] o_identify;
  logic o_data_request;
  logic i_data_valid;
  logic [31:0] i_data;
  logic o_tx_valid;
  logic [7:0] o_tx_data;
  logic i_tx_busy;
  logic o_rx_ready;
  logic i_rx_valid;
  logic [7:0] i_rx_data;
  modport master (
    input i_start, i_cmd, i_bank, i_address, i_length, i_data_valid, i_data, i_tx_busy, i_rx_valid, i_rx_data,
    output o_busy, o_done, o_error, o_identify, o_data_request, o_tx_valid, o_tx_data, o_rx_ready
  );
  modport slave (
    output i_start, i_cmd, i_bank, i_address, i_length, i_data_valid, i_data, i_tx_busy, i_rx_valid, i_rx_data,
    input o_busy, o_done, o_error, o_identify, o_data_request, o_tx_valid, o_tx_data, o_rx_ready
  );
endinterface

// File: rtl/usb_cmd_rsp_parser.sv
// usb_cmd_rsp_parser: matches the "CMP"+id completion and captures identify bytes ahead of it
module usb_cmd_rsp_parser
  import usb_cmd_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        clear,
  input  logic        rx_strobe,
  input  logic        identify_mode,
  input  logic [7:0]  cmd,
  input  logic [7:0]  rx_data,
  output logic        match,
  output logic        mismatch,
  output logic [31:0] identify
);
  logic [2:0] pos;
  logic checking;
  logic [31:0] pattern;
  logic [7:0] expected;
  // identify payload occupies positions 0..3, so the check index is pos[1:0] in both modes
  always_comb begin
    checking = !identify_mode || pos[2];
    pattern = {RSP_COMPLETE, cmd};
    expected = pattern[{~pos[1:0], 3'b000} +: 8];
    match = rx_strobe && checking && rx_data == expected && pos[1:0] == 2'd3;
    mismatch = rx_strobe && checking && rx_data != expected;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pos <= 3'd0;
      identify <= 32'd0;
    end else if (clear) begin
      pos <= 3'd0;
    end else if (rx_strobe) begin
      pos <= pos + 3'd1;
      if (!checking) identify <= {identify[23:0], rx_data};
    end
  end
endmodule

// File: rtl/usb_cmd_initiator.sv
// usb_cmd_initiator: sends "CMD"+id, parameters and data words, then parses the "CMP"+id reply
// Optional response timeout enabled by defining USB_CMD_INITIATOR_TIMEOUT_EN.
module usb_cmd_initiator
  import usb_cmd_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input logic i_clk,
  input logic i_reset,
  usb_cmd_initiator_if.master bus
);
`ifdef USB_CMD_INITIATOR_TIMEOUT_EN
  localparam logic TMO_EN = 1'b1;
`else
  localparam logic TMO_EN = 1'b0;
`endif
  state_t state, state_n;
  logic [7:0] cmd_q, cmd_n, tx_byte;
  logic [3:0] bank_q, bank_n, idx, idx_n;
  logic [23:0] addr_q, addr_n, tmo, tmo_n;
  logic [19:0] len_q, len_n, cnt, cnt_n;
  logic [31:0] word, word_n, trig, param_d, identify;
  logic [63:0] param_w;
  logic accept, err_n, rsp_strobe, match, mismatch, timeout, tx_valid_n;
  assign rsp_strobe = state == RSP && bus.i_rx_valid;
  assign timeout = TMO_EN && rsp_strobe == 1'b0 && state == RSP && tmo == TIMEOUT_CYCLES - 24'd1;
  assign bus.o_identify = identify;
  usb_cmd_rsp_parser u_parser (
    .i_clk(i_clk), .i_reset(i_reset), .clear(state != RSP), .rx_strobe(rsp_strobe),
    .identify_mode(cmd_q == CMD_ID_I), .cmd(cmd_q), .rx_data(bus.i_rx_data),
    .match(match), .mismatch(mismatch), .identify(identify)
  );
  always_comb begin
    state_n = state;
    cmd_n = cmd_q;
    bank_n = bank_q;
    addr_n = addr_q;
    len_n = len_q;
    cnt_n = cnt;
    idx_n = idx;
    word_n = word;
    err_n = 1'b0;
    accept = bus.o_tx_valid && !bus.i_tx_busy;
    tmo_n = (state == RSP && !bus.i_rx_valid) ? tmo + 24'd1 : 24'd0;
    case (state)
      IDLE: if (bus.i_start) begin
        cmd_n = bus.i_cmd;
        bank_n = bus.i_bank;
        addr_n = bus.i_address;
        len_n = bus.i_length;
        idx_n = 4'd0;
        state_n = known_cmd(bus.i_cmd) ? TRIGGER : DONE;
        err_n = !known_cmd(bus.i_cmd);
      end
      TRIGGER: if (accept) begin
        idx_n = idx == 4'd3 ? 4'd0 : idx + 4'd1;
        state_n = idx != 4'd3 ? TRIGGER : cmd_q == CMD_ID_I ? RSP : PARAM;
      end
      PARAM: if (accept) begin
        if (idx == (cmd_q == CMD_ID_W ? PARAM_LEN_W : PARAM_LEN_D) - 4'd1) begin
          idx_n = 4'd0;
          cnt_n = len_q;
          state_n = FETCH;
        end else idx_n = idx + 4'd1;
      end
      FETCH: if (bus.i_data_valid) begin
        word_n = bus.i_data;
        state_n = DATA;
      end
      DATA: if (accept) begin
        idx_n = idx == 4'd3 ? 4'd0 : idx + 4'd1;
        // the counter never wraps: the last word is the one sent while it reads zero
        if (idx == 4'd3 && cnt == 20'd0) state_n = cmd_q == CMD_ID_W ? RSP : DONE;
        else if (idx == 4'd3) begin
          cnt_n = cnt - 20'd1;
          state_n = FETCH;
        end
      end
      RSP: if (match || mismatch || timeout) begin
        state_n = DONE;
        err_n = !match;
      end
      default: state_n = IDLE;
    endcase
    trig = {CMD_TRIGGER, cmd_n};
    param_w = {6'b0, addr_n, 6'b0, bank_n, 4'b0, len_n};
    param_d = {12'b0, len_n};
    tx_valid_n = state_n == TRIGGER || state_n == PARAM || state_n == DATA;
    tx_byte = state_n == TRIGGER ? trig[{~idx_n[1:0], 3'b000} +: 8]
      : state_n == DATA ? word_n[{~idx_n[1:0], 3'b000} +: 8]
      : state_n != PARAM ? 8'h00
      : cmd_n == CMD_ID_W ? param_w[{~idx_n[2:0], 3'b000} +: 8] : param_d[{~idx_n[1:0], 3'b000} +: 8];
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      cmd_q <= 8'd0;
      bank_q <= 4'd0;
      addr_q <= 24'd0;
      len_q <= 20'd0;
      cnt <= 20'd0;
      idx <= 4'd0;
      word <= 32'd0;
      tmo <= 24'd0;
      bus.o_busy <= 1'b0;
      bus.o_done <= 1'b0;
      bus.o_error <= 1'b0;
      bus.o_data_request <= 1'b0;
      bus.o_tx_valid <= 1'b0;
      bus.o_tx_data <= 8'd0;
    end else begin
      state <= state_n;
      cmd_q <= cmd_n;
      bank_q <= bank_n;
      addr_q <= addr_n;
      len_q <= len_n;
      cnt <= cnt_n;
      idx <= idx_n;
      word <= word_n;
      tmo <= tmo_n;
      bus.o_busy <= state_n != IDLE && state_n != DONE;
      bus.o_done <= state_n == DONE;
      bus.o_error <= state_n == DONE && err_n;
      bus.o_data_request <= state_n == FETCH && state != FETCH;
      bus.o_tx_valid <= tx_valid_n;
      bus.o_tx_data <= tx_byte;
    end
    bus.o_rx_ready <= 1'b1;
  end
endmodule
